// File: rtl/cost_server.sv
// Cost-table server: loads a 64-entry 7-bit cost table, serves table[W][J] with one-cycle latency,
// and captures the assignment engine's result. The optional query counter is enabled by COST_SERVER_QCNT_EN.
module cost_server (
   input  logic        CLK,
   input  logic        RST,
   input  logic        load_valid,
   input  logic [6:0]  load_data,
   output logic        load_ready,
   input  logic [2:0]  W,
   input  logic [2:0]  J,
   output logic [6:0]  Cost,
   input  logic        Valid,
   input  logic [3:0]  MatchCount,
   input  logic [9:0]  MinCost,
   output logic        Done,
   output logic [9:0]  ResMinCost,
   output logic [3:0]  ResMatchCount,
   output logic [19:0] QueryCount
);

   typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  wr_ptr;
   logic [6:0]  cost_table [64];
   logic [5:0]  rd_idx;
   logic        accept;
   logic        capture;

   assign rd_idx  = {W, J};
   assign accept  = (state == LOAD) && load_valid;
   assign capture = (state == SERVE) && Valid;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      case (state)
         LOAD: begin
            load_ready = 1'b1;
            if (load_valid && (wr_ptr == 6'd63)) state_nxt = SERVE;
         end
         SERVE:   if (Valid) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = LOAD;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge CLK) begin
      if (RST) state <= LOAD;
      else     state <= state_nxt;
   end

   // NOTE: the table must read as all-zero after reset, so it is built from resettable flops, not RAM.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= 6'd0;
         for (int i = 0; i < 64; i++) cost_table[i] <= 7'd0;
      end else if (accept) begin
         cost_table[wr_ptr] <= load_data;
         wr_ptr             <= wr_ptr + 6'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || (state == LOAD)) Cost <= 7'd0;
      else                        Cost <= cost_table[rd_idx];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Done          <= 1'b0;
         ResMinCost    <= 10'd0;
         ResMatchCount <= 4'd0;
      end else if (capture) begin
         Done          <= 1'b1;
         ResMinCost    <= MinCost;
         ResMatchCount <= MatchCount;
      end
   end

`ifdef COST_SERVER_QCNT_EN
   logic [5:0] prev_idx;
   logic       first_serve;

   // first_serve makes the opening SERVE cycle count even when {W,J} equals the reset prev_idx.
   always_ff @(posedge CLK) begin
      if (RST) begin
         QueryCount  <= 20'd0;
         prev_idx    <= 6'd0;
         first_serve <= 1'b1;
      end else begin
         prev_idx <= rd_idx;
         if (state == LOAD) begin
            first_serve <= 1'b1;
         end else if (state == SERVE) begin
            first_serve <= 1'b0;
            if ((first_serve || (rd_idx != prev_idx)) && (QueryCount != 20'hFFFFF))
               QueryCount <= QueryCount + 20'd1;
         end
      end
   end
`else
   assign QueryCount = 20'd0;
`endif

endmodule

// File: tb/tb_cost_server.sv
// Scoreboard bench for cost_server: stimulus queues expected outputs, a negedge monitor compares them.
module tb_cost_server;

   logic        CLK = 1'b0;
   logic        RST;
   logic        load_valid;
   logic [6:0]  load_data;
   logic        load_ready;
   logic [2:0]  W, J;
   logic [6:0]  Cost;
   logic        Valid;
   logic [3:0]  MatchCount;
   logic [9:0]  MinCost;
   logic        Done;
   logic [9:0]  ResMinCost;
   logic [3:0]  ResMatchCount;
   logic [19:0] QueryCount;

   cost_server dut (
      .CLK(CLK), .RST(RST),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .W(W), .J(J), .Cost(Cost),
      .Valid(Valid), .MatchCount(MatchCount), .MinCost(MinCost),
      .Done(Done), .ResMinCost(ResMinCost), .ResMatchCount(ResMatchCount),
      .QueryCount(QueryCount)
   );

   always #5 CLK = ~CLK;

   typedef enum int {S_READY, S_COST, S_DONE, S_RMIN, S_RMC, S_QC, S_ACC, S_ACCCLR} sel_t;
   typedef struct {
      sel_t  sel;
      int    val;
      string name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   acc_cnt = 0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic expect_val(input sel_t sel, input int val, input string name);
      exp_t e;
      e.sel = sel; e.val = val; e.name = name;
      exp_q.push_back(e);
   endtask

   function automatic int qexp(input int n);
`ifdef COST_SERVER_QCNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   // Returns 1 ns after a rising edge, where inputs are driven and expectations queued.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: compare queued expectations against registered outputs, then count accepts for this cycle.
   always @(negedge CLK) begin
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.sel)
            S_READY:  check(e.name, int'(load_ready), e.val);
            S_COST:   check(e.name, int'(Cost), e.val);
            S_DONE:   check(e.name, int'(Done), e.val);
            S_RMIN:   check(e.name, int'(ResMinCost), e.val);
            S_RMC:    check(e.name, int'(ResMatchCount), e.val);
            S_QC:     check(e.name, int'(QueryCount), e.val);
            S_ACC:    check(e.name, acc_cnt, e.val);
            S_ACCCLR: acc_cnt = 0;
            default:  ;
         endcase
      end
      if (load_valid && load_ready && !RST) acc_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic expect_idle_reset(input string tag);
      expect_val(S_READY, 1, {tag, "_ready"});
      expect_val(S_COST,  0, {tag, "_cost"});
      expect_val(S_DONE,  0, {tag, "_done"});
      expect_val(S_RMIN,  0, {tag, "_resmin"});
      expect_val(S_RMC,   0, {tag, "_resmc"});
      expect_val(S_QC,    0, {tag, "_qcnt"});
   endtask

   initial begin
      RST = 1'b1; load_valid = 1'b0; load_data = '0; W = '0; J = '0;
      Valid = 1'b0; MatchCount = '0; MinCost = '0;
      step(); step();
      expect_idle_reset("rst0");

      // Partial load of 30 entries with Valid held high: no capture may happen in LOAD.
      RST = 1'b0; Valid = 1'b1; MinCost = 10'd77; MatchCount = 4'd3;
      for (int i = 0; i < 30; i++) begin
         load_valid = 1'b1; load_data = 7'(i);
         step();
      end
      expect_val(S_DONE,  0, "load_valid_ignored_done");
      expect_val(S_READY, 1, "partial_ready");

      // Reset wins over load_valid and Valid in the same cycle.
      RST = 1'b1; load_data = 7'h55;
      step();
      RST = 1'b0; load_valid = 1'b0; W = 3'd1; J = 3'd2;
      expect_idle_reset("rst_mid");
      step();
      expect_val(S_COST, 0, "load_cost_zero");
      expect_val(S_DONE, 0, "load_done_zero");
      Valid = 1'b0;

      // Continuous load: table[w][j] = w*8+j.
      expect_val(S_ACCCLR, 0, "clr");
      W = 3'd1; J = 3'd1;
      for (int i = 0; i < 64; i++) begin
         load_valid = 1'b1; load_data = 7'(i);
         step();
      end
      load_data = 7'h7F;
      expect_val(S_READY, 0,  "serve_ready_low");
      expect_val(S_ACC,   64, "load_accepts");
      expect_val(S_COST,  0,  "last_load_edge_cost");
      expect_val(S_QC,    0,  "qcnt_before_serve");

      step(); expect_val(S_COST, 9, "cost_1_1"); expect_val(S_QC, qexp(1), "qcnt_first");
      load_valid = 1'b0;
      step(); expect_val(S_QC, qexp(1), "qcnt_hold_a");
      step(); expect_val(S_QC, qexp(1), "qcnt_hold_b");
      J = 3'd2;
      step(); expect_val(S_COST, 10, "cost_1_2"); expect_val(S_QC, qexp(2), "qcnt_change");
      W = 3'd5; J = 3'd3;
      step(); expect_val(S_COST, 43, "cost_5_3"); expect_val(S_QC, qexp(3), "qcnt_5_3");
      W = 3'd7; J = 3'd7;
      step(); expect_val(S_COST, 63, "cost_7_7"); expect_val(S_QC, qexp(4), "qcnt_7_7");
      step(); expect_val(S_COST, 63, "cost_7_7_hold"); expect_val(S_QC, qexp(4), "qcnt_7_7_hold");
      W = 3'd0; J = 3'd0;
      step(); expect_val(S_COST, 0, "cost_0_0"); expect_val(S_QC, qexp(5), "qcnt_0_0");

      // Result capture, then a second pulse that must be ignored.
      Valid = 1'b1; MinCost = 10'd320; MatchCount = 4'd2;
      step();
      expect_val(S_DONE, 1, "cap_done"); expect_val(S_RMIN, 320, "cap_min");
      expect_val(S_RMC, 2, "cap_mc"); expect_val(S_QC, qexp(5), "cap_qcnt");
      MinCost = 10'd100; MatchCount = 4'd5; W = 3'd2; J = 3'd6;
      step();
      expect_val(S_DONE, 1, "second_done"); expect_val(S_RMIN, 320, "second_min");
      expect_val(S_RMC, 2, "second_mc"); expect_val(S_COST, 22, "done_cost_2_6");
      expect_val(S_QC, qexp(5), "done_qcnt_frozen");
      Valid = 1'b0;

      // Reset, then a stalled load with load_valid toggling every other cycle.
      RST = 1'b1;
      step();
      RST = 1'b0;
      expect_idle_reset("rst_done");
      expect_val(S_ACCCLR, 0, "clr");
      W = 3'd3; J = 3'd4;
      for (int c = 0; c < 128; c++) begin
         load_valid = (c % 2 == 0);
         load_data  = 7'(c / 2);
         step();
      end
      expect_val(S_ACC,   64, "stall_accepts");
      expect_val(S_READY, 0,  "stall_ready_low");
      expect_val(S_COST,  28, "stall_cost_3_4");
      expect_val(S_QC,    qexp(1), "stall_qcnt_first");
      load_valid = 1'b1; load_data = 7'h7F;
      for (int idx = 0; idx < 64; idx++) begin
         {W, J} = 6'(idx);
         step();
         expect_val(S_COST, idx, $sformatf("table_%0d", idx));
      end
      expect_val(S_QC, qexp(65), "stall_qcnt_sweep");
      load_valid = 1'b0;
      step(); step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cost_server.md
COST_SERVER -- requirements
Module: cost_server

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous active-high reset
load_valid  in  1  cost-table load entry present
load_data  in  7  cost entry; row-major order, index = W*8+J
load_ready  out  1  entry accepted this cycle when load_valid&&load_ready
W  in  3  worker index from the assignment engine
J  in  3  job index from the assignment engine
Cost  out  7  registered table[W][J]
Valid  in  1  engine result strobe
MatchCount  in  4  engine result: number of minimum-cost assignments
MinCost  in  10  engine result: minimum total cost
Done  out  1  result captured; sticky until RST
ResMinCost  out  10  captured MinCost
ResMatchCount  out  4  captured MatchCount
QueryCount  out  20  number of distinct {W,J} queries served

Function
REQ-003 The FSM SHALL have states LOAD, SERVE and DONE, and SHALL enter LOAD on reset.
REQ-004 In LOAD, load_ready SHALL be 1; in SERVE and DONE it SHALL be 0.
REQ-005 Each accepted entry SHALL be written to table[idx], where idx is a 6-bit write pointer that starts at 0 and increments by 1 per accepted entry.
REQ-006 When the entry with idx=63 is accepted, the FSM SHALL enter SERVE on the next edge, and the pointer SHALL wrap to 0.
REQ-007 load_valid SHALL be ignored outside LOAD; a load_valid gap SHALL stall loading without changing the pointer.
REQ-008 In SERVE and DONE, Cost SHALL be registered from table[W][J] sampled at each edge.
REQ-009 Latency SHALL be 1: W,J presented before edge k give Cost valid after edge k, so Cost is stable at edge k+1.
REQ-010 In LOAD, Cost SHALL be held at 0.
REQ-011 In SERVE, on the first cycle with Valid=1, the block SHALL capture MinCost into ResMinCost and MatchCount into ResMatchCount, set Done to 1 and enter DONE.
REQ-012 In DONE, further Valid pulses SHALL NOT modify ResMinCost, ResMatchCount or Done, and Cost serving SHALL continue.
REQ-013 Valid asserted during LOAD SHALL be ignored, with no capture.
REQ-014 The table SHALL be 64 x 7-bit, indexed {W,J}, and SHALL be read-only outside LOAD.
REQ-015 QueryCount SHALL increment by 1 in SERVE on each cycle where {W,J} differs from its value on the previous cycle.
REQ-016 The first SERVE cycle SHALL count as a query.
REQ-017 QueryCount SHALL saturate at 2^20-1 and SHALL NOT change in LOAD or DONE.

Reset
REQ-018 On RST=1 at an edge, the following SHALL be reset: state to LOAD, write pointer to 0, Cost to 0, Done to 0, ResMinCost to 0, ResMatchCount to 0, QueryCount to 0, and the previous-{W,J} register to 0.
REQ-019 Table contents SHALL be cleared to 0 on reset.
REQ-020 Reset asserted mid-LOAD or mid-SERVE SHALL abort the operation; a full 64-entry reload SHALL be required afterwards.
REQ-021 RST SHALL take priority over load_valid and Valid in the same cycle.

Configuration
REQ-022 The macro COST_SERVER_QCNT_EN SHALL control the query counter.
REQ-023 With COST_SERVER_QCNT_EN defined, QueryCount SHALL behave per REQ-015 to REQ-017.
REQ-024 Without COST_SERVER_QCNT_EN, the counter and the previous-{W,J} register SHALL be absent, and QueryCount SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
REQ-025 Load scenario: load entries table[w][j]=w*8+j with load_valid held high for 64 cycles -> load_ready drops after the 64th accept; state is SERVE.
REQ-026 Latency scenario: after the load of REQ-025, drive W=5, J=3 -> Cost=43 one edge later; then W=7, J=7 -> Cost=63 on the next edge.
REQ-027 Stall scenario: toggle load_valid every other cycle -> exactly 64 accepts over 128 cycles, and the table contents match REQ-025.
REQ-028 Capture scenario: in SERVE, pulse Valid with MinCost=10'd320 and MatchCount=4'd2 -> Done=1, ResMinCost=320, ResMatchCount=2; a second pulse with MinCost=100 -> outputs unchanged.
REQ-029 Counter scenario (macro defined): hold W=1,J=1 for 3 cycles, then W=1,J=2 for 1 cycle -> QueryCount=2. With the macro undefined -> QueryCount=0.
REQ-030 Reset scenario: assert RST after 30 load accepts -> load_ready=1, pointer=0, and Cost=0 for all queries until reloaded; Valid during LOAD -> Done stays 0.
